// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types, historical wiring tables and mod-26 helpers
// for the Enigma rotor/reflector datapath.
package enigma_pkg;

    typedef logic [4:0] alpha_t;
    typedef alpha_t [0:25] wiring_t;

    typedef enum logic [1:0] {
        IDLE,
        MAP,
        OUT
    } state_t;

    localparam int NUM_ROTORS = 5;

    function automatic wiring_t str2wiring(input logic [8*26-1:0] s);
        wiring_t w;
        w = '0;
        for (int i = 0; i < 26; i++) begin
            w[i] = alpha_t'(s[8*(25-i) +: 8] - 8'd65);
        end
        return w;
    endfunction

    function automatic wiring_t invert(input wiring_t w);
        wiring_t v;
        v = '0;
        for (int i = 0; i < 26; i++) begin
            v[w[i]] = alpha_t'(i);
        end
        return v;
    endfunction

    function automatic alpha_t add26(input alpha_t a, input alpha_t b);
        logic [5:0] t;
        t = {1'b0, a} + {1'b0, b};
        return (t >= 6'd26) ? alpha_t'(t - 6'd26) : alpha_t'(t);
    endfunction

    function automatic alpha_t sub26(input alpha_t a, input alpha_t b);
        logic [5:0] t;
        t = {1'b0, a} + 6'd26 - {1'b0, b};
        return (t >= 6'd26) ? alpha_t'(t - 6'd26) : alpha_t'(t);
    endfunction

    localparam wiring_t ROTOR_FWD [NUM_ROTORS] = '{
        str2wiring("EKMFLGDQVZNTOWYHXUSPAIBRCJ"),
        str2wiring("AJDKSIRUXBLHWTMCQGZNPYFVOE"),
        str2wiring("BDFHJLCPRTXVZNYEIWGAKMUSQO"),
        str2wiring("ESOVPZJAYQUIRHXLNFTGKDCMWB"),
        str2wiring("VZBRGITYUPSDNHLXAWMJQOFECK")
    };

    localparam wiring_t ROTOR_INV [NUM_ROTORS] = '{
        invert(ROTOR_FWD[0]),
        invert(ROTOR_FWD[1]),
        invert(ROTOR_FWD[2]),
        invert(ROTOR_FWD[3]),
        invert(ROTOR_FWD[4])
    };

    localparam alpha_t ROTOR_NOTCH [NUM_ROTORS] = '{
        5'd16, 5'd4, 5'd21, 5'd9, 5'd25
    };

    localparam wiring_t REFLECTOR_B =
        str2wiring("YRUHQSLDPXNGOKMIEBFZCWVJAT");

endpackage

// File: rtl/enigma_rotor_map.sv
// enigma_rotor_map: one rotor's substitution, either direction,
// compensated for rotor offset (position minus ring setting).
module enigma_rotor_map
    import enigma_pkg::*;
#(
    parameter int ROTOR = 0
) (
    input  logic       i_rev,
    input  logic [4:0] i_char,
    input  logic [4:0] i_pos,
    input  logic [4:0] i_ring,
    output logic [4:0] o_char
);

    alpha_t w_shift;
    alpha_t w_idx;
    alpha_t w_wired;

    assign w_shift = sub26(i_pos, i_ring);
    assign w_idx   = add26(i_char, w_shift);
    assign w_wired = i_rev ? ROTOR_INV[ROTOR][w_idx]
                           : ROTOR_FWD[ROTOR][w_idx];
    assign o_char  = sub26(w_wired, w_shift);

endmodule

// File: rtl/enigma_rotor_stage.sv
// enigma_rotor_stage: three-rotor Enigma core with reflector B.
// Steps rotors on accept, maps the letter, hands it off downstream.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int LEFT_ROTOR  = 0,
    parameter int MID_ROTOR   = 1,
    parameter int RIGHT_ROTOR = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] char_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] char_out,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       cfg_we,
    input  logic [4:0] cfg_pos_l,
    input  logic [4:0] cfg_pos_m,
    input  logic [4:0] cfg_pos_r,
    input  logic [4:0] cfg_ring_l,
    input  logic [4:0] cfg_ring_m,
    input  logic [4:0] cfg_ring_r,
    output logic       cfg_err,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r
);

    state_t r_state;
    state_t w_next;

    logic   w_in_ready;
    logic   w_accept;
    logic   w_cfg_take;
    logic   w_cfg_bad;
    logic   w_bypass_in;
    logic   w_step_m;
    logic   w_step_l;

    alpha_t r_pos_l;
    alpha_t r_pos_m;
    alpha_t r_pos_r;
    alpha_t r_ring_l;
    alpha_t r_ring_m;
    alpha_t r_ring_r;
    alpha_t r_char;
    logic   r_bypass;
    alpha_t r_char_out;
    logic   r_out_valid;
    logic   r_cfg_err;

    alpha_t w_map_in;
    alpha_t w_rf;
    alpha_t w_mf;
    alpha_t w_lf;
    alpha_t w_refl;
    alpha_t w_lr;
    alpha_t w_mr;
    alpha_t w_rr;

    assign w_accept    = w_in_ready & in_valid;
    assign w_cfg_take  = cfg_we & (r_state == IDLE);
    assign w_bypass_in = (char_in > 5'd25);
    assign w_cfg_bad   = (cfg_pos_l  > 5'd25) | (cfg_pos_m  > 5'd25) |
                         (cfg_pos_r  > 5'd25) | (cfg_ring_l > 5'd25) |
                         (cfg_ring_m > 5'd25) | (cfg_ring_r > 5'd25);

    // Middle rotor double-steps on its own notch; left follows it.
    assign w_step_l = (r_pos_m == ROTOR_NOTCH[MID_ROTOR]);
    assign w_step_m = (r_pos_r == ROTOR_NOTCH[RIGHT_ROTOR]) | w_step_l;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; config steals the IDLE slot.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = ~cfg_we;
                if (in_valid && !cfg_we) begin
                    w_next = MAP;
                end
            end
            MAP: begin
                w_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Rotor positions, ring settings and config error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos_l   <= '0;
            r_pos_m   <= '0;
            r_pos_r   <= '0;
            r_ring_l  <= '0;
            r_ring_m  <= '0;
            r_ring_r  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (w_cfg_take) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_pos_l  <= cfg_pos_l;
                    r_pos_m  <= cfg_pos_m;
                    r_pos_r  <= cfg_pos_r;
                    r_ring_l <= cfg_ring_l;
                    r_ring_m <= cfg_ring_m;
                    r_ring_r <= cfg_ring_r;
                end
            end else if (w_accept && !w_bypass_in) begin
                r_pos_r <= add26(r_pos_r, 5'd1);
                if (w_step_m) begin
                    r_pos_m <= add26(r_pos_m, 5'd1);
                end
                if (w_step_l) begin
                    r_pos_l <= add26(r_pos_l, 5'd1);
                end
            end
        end
    end

    // Capture the incoming letter and whether it bypasses the rotors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_char   <= '0;
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            r_char   <= char_in;
            r_bypass <= w_bypass_in;
        end
    end

    // Out-of-range codes never reach the tables.
    assign w_map_in = r_bypass ? '0 : r_char;

    enigma_rotor_map #(.ROTOR(RIGHT_ROTOR)) u_r_fwd (
        .i_rev  (1'b0),
        .i_char (w_map_in),
        .i_pos  (r_pos_r),
        .i_ring (r_ring_r),
        .o_char (w_rf)
    );

    enigma_rotor_map #(.ROTOR(MID_ROTOR)) u_m_fwd (
        .i_rev  (1'b0),
        .i_char (w_rf),
        .i_pos  (r_pos_m),
        .i_ring (r_ring_m),
        .o_char (w_mf)
    );

    enigma_rotor_map #(.ROTOR(LEFT_ROTOR)) u_l_fwd (
        .i_rev  (1'b0),
        .i_char (w_mf),
        .i_pos  (r_pos_l),
        .i_ring (r_ring_l),
        .o_char (w_lf)
    );

    assign w_refl = REFLECTOR_B[w_lf];

    enigma_rotor_map #(.ROTOR(LEFT_ROTOR)) u_l_rev (
        .i_rev  (1'b1),
        .i_char (w_refl),
        .i_pos  (r_pos_l),
        .i_ring (r_ring_l),
        .o_char (w_lr)
    );

    enigma_rotor_map #(.ROTOR(MID_ROTOR)) u_m_rev (
        .i_rev  (1'b1),
        .i_char (w_lr),
        .i_pos  (r_pos_m),
        .i_ring (r_ring_m),
        .o_char (w_mr)
    );

    enigma_rotor_map #(.ROTOR(RIGHT_ROTOR)) u_r_rev (
        .i_rev  (1'b1),
        .i_char (w_mr),
        .i_pos  (r_pos_r),
        .i_ring (r_ring_r),
        .o_char (w_rr)
    );

    // Register the mapped letter in MAP, hold it until taken in OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_char_out  <= '0;
            r_out_valid <= 1'b0;
        end else if (r_state == MAP) begin
            r_char_out  <= r_bypass ? r_char : w_rr;
            r_out_valid <= 1'b1;
        end else if (r_state == OUT && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready & rst_n;
    assign char_out  = r_char_out;
    assign out_valid = r_out_valid;
    assign cfg_err   = r_cfg_err;
    assign pos_l     = r_pos_l;
    assign pos_m     = r_pos_m;
    assign pos_r     = r_pos_r;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// tb_enigma_rotor_stage: directed and random checks against a
// letter-level Enigma model built from the historical wiring strings.
module tb_enigma_rotor_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] char_in;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] char_out;
    logic       out_valid;
    logic       out_ready;
    logic       cfg_we;
    logic [4:0] cfg_pos_l, cfg_pos_m, cfg_pos_r;
    logic [4:0] cfg_ring_l, cfg_ring_m, cfg_ring_r;
    logic       cfg_err;
    logic [4:0] pos_l, pos_m, pos_r;

    always #5 clk = ~clk;

    enigma_rotor_stage #(
        .LEFT_ROTOR  (0),
        .MID_ROTOR   (1),
        .RIGHT_ROTOR (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .char_out   (char_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg_we     (cfg_we),
        .cfg_pos_l  (cfg_pos_l),
        .cfg_pos_m  (cfg_pos_m),
        .cfg_pos_r  (cfg_pos_r),
        .cfg_ring_l (cfg_ring_l),
        .cfg_ring_m (cfg_ring_m),
        .cfg_ring_r (cfg_ring_r),
        .cfg_err    (cfg_err),
        .pos_l      (pos_l),
        .pos_m      (pos_m),
        .pos_r      (pos_r)
    );

    int total = 0;
    int bad   = 0;

    string WIRE[5] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK"
    };
    string REFL = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    int NOTCH[5] = '{16, 4, 21, 9, 25};

    int m_pl, m_pm, m_pr;
    int m_rl, m_rm, m_rr;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wire_at(input int r, input int i);
        return int'(WIRE[r][i]) - 65;
    endfunction

    function automatic int rot_fw(input int r, input int c,
                                  input int p, input int g);
        int s;
        s = (p - g + 26) % 26;
        return (wire_at(r, (c + s) % 26) - s + 26) % 26;
    endfunction

    function automatic int rot_bw(input int r, input int c,
                                  input int p, input int g);
        int s, t, j;
        s = (p - g + 26) % 26;
        t = (c + s) % 26;
        j = 0;
        for (int k = 0; k < 26; k++)
            if (wire_at(r, k) == t) j = k;
        return (j - s + 26) % 26;
    endfunction

    function automatic int encipher(input int c);
        int x;
        x = rot_fw(2, c, m_pr, m_rr);
        x = rot_fw(1, x, m_pm, m_rm);
        x = rot_fw(0, x, m_pl, m_rl);
        x = int'(REFL[x]) - 65;
        x = rot_bw(0, x, m_pl, m_rl);
        x = rot_bw(1, x, m_pm, m_rm);
        x = rot_bw(2, x, m_pr, m_rr);
        return x;
    endfunction

    task automatic model_step();
        if (m_pm == NOTCH[1]) begin
            m_pl = (m_pl + 1) % 26;
            m_pm = (m_pm + 1) % 26;
        end else if (m_pr == NOTCH[2]) begin
            m_pm = (m_pm + 1) % 26;
        end
        m_pr = (m_pr + 1) % 26;
    endtask

    task automatic model_clear();
        m_pl = 0; m_pm = 0; m_pr = 0;
        m_rl = 0; m_rm = 0; m_rr = 0;
    endtask

    task automatic check_pos(input string tag);
        chk({tag, "_l"}, int'(pos_l), m_pl);
        chk({tag, "_m"}, int'(pos_m), m_pm);
        chk({tag, "_r"}, int'(pos_r), m_pr);
    endtask

    task automatic cfg(input int pl, input int pm, input int pr,
                       input int rl, input int rm, input int rr);
        bit badv;
        badv = (pl > 25) || (pm > 25) || (pr > 25) ||
               (rl > 25) || (rm > 25) || (rr > 25);
        cfg_we = 1'b1;
        cfg_pos_l = 5'(pl); cfg_pos_m = 5'(pm); cfg_pos_r = 5'(pr);
        cfg_ring_l = 5'(rl); cfg_ring_m = 5'(rm); cfg_ring_r = 5'(rr);
        #1;
        chk("cfg_rdy", int'(in_ready), 0);
        tick();
        cfg_we = 1'b0;
        if (!badv) begin
            m_pl = pl; m_pm = pm; m_pr = pr;
            m_rl = rl; m_rm = rm; m_rr = rr;
        end
        chk("cfg_err", int'(cfg_err), int'(badv));
        check_pos("pos_cfg");
        tick();
        chk("cfg_err_end", int'(cfg_err), 0);
    endtask

    task automatic send(input int c, input int stall,
                        input bit noise, output int got);
        int want, n;
        chk("rdy_idle", int'(in_ready), 1);
        char_in = 5'(c);
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        if (c <= 25) begin
            model_step();
            want = encipher(c);
        end else begin
            want = c;
        end
        check_pos("pos_acc");
        chk("rdy_busy", int'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 4) begin
            tick();
            n++;
        end
        chk("latency", int'(out_valid && n <= 2), 1);
        for (int k = 0; k < stall; k++) begin
            if (noise) begin
                cfg_we = 1'b1;
                cfg_pos_l = 5'($urandom_range(0, 31));
                cfg_pos_m = 5'($urandom_range(0, 31));
                cfg_pos_r = 5'($urandom_range(0, 31));
                cfg_ring_l = 5'($urandom_range(0, 31));
                cfg_ring_m = 5'($urandom_range(0, 31));
                cfg_ring_r = 5'($urandom_range(0, 31));
            end
            tick();
            chk("hold_v", int'(out_valid), 1);
            chk("hold_c", int'(char_out), want);
            chk("hold_rdy", int'(in_ready), 0);
            chk("hold_err", int'(cfg_err), 0);
            check_pos("pos_hold");
        end
        cfg_we = 1'b0;
        got = int'(char_out);
        chk("char_out", got, want);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ov_drop", int'(out_valid), 0);
        chk("rdy_back", int'(in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int got;
    int exp_a[5] = '{1, 3, 25, 6, 14};
    int exp_ds[3][3] = '{'{0, 3, 21}, '{0, 4, 22}, '{1, 5, 23}};
    int sel, cc;
    int f[6];

    initial begin
        rst_n = 1'b0;
        char_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_we = 1'b0;
        cfg_pos_l = '0; cfg_pos_m = '0; cfg_pos_r = '0;
        cfg_ring_l = '0; cfg_ring_m = '0; cfg_ring_r = '0;
        model_clear();
        tick();
        tick();
        chk("rst_rdy", int'(in_ready), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_co", int'(char_out), 0);
        chk("rst_err", int'(cfg_err), 0);
        check_pos("rst_pos");
        rst_n = 1'b1;
        tick();

        cfg(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            send(0, 0, 1'b0, got);
            chk("aaaaa", got, exp_a[i]);
        end
        chk("aaf_r", int'(pos_r), 5);

        cfg(0, 3, 20, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send($urandom_range(0, 25), 0, 1'b0, got);
            chk("dstep_l", int'(pos_l), exp_ds[i][0]);
            chk("dstep_m", int'(pos_m), exp_ds[i][1]);
            chk("dstep_r", int'(pos_r), exp_ds[i][2]);
        end

        cfg(25, 25, 25, 0, 0, 0);
        send(7, 0, 1'b0, got);
        chk("zza_l", int'(pos_l), 25);
        chk("zza_m", int'(pos_m), 25);
        chk("zza_r", int'(pos_r), 0);

        send(28, 0, 1'b0, got);
        chk("bypass", got, 28);
        chk("byp_pos", int'(pos_r), 0);

        send(11, 5, 1'b1, got);

        cfg(4, 9, 14, 2, 3, 5);
        cfg(1, 2, 3, 0, 27, 0);
        send(19, 1, 1'b0, got);

        in_valid = 1'b1; char_in = 5'd4;
        cfg_we = 1'b1;
        cfg_pos_l = 5'd2; cfg_pos_m = 5'd3; cfg_pos_r = 5'd4;
        cfg_ring_l = 5'd1; cfg_ring_m = 5'd1; cfg_ring_r = 5'd1;
        #1;
        chk("both_rdy", int'(in_ready), 0);
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        m_pl = 2; m_pm = 3; m_pr = 4;
        m_rl = 1; m_rm = 1; m_rr = 1;
        check_pos("both_pos");
        tick();
        tick();
        chk("both_ov", int'(out_valid), 0);
        chk("both_rdy2", int'(in_ready), 1);
        send(4, 0, 1'b0, got);

        char_in = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        model_clear();
        chk("mid_rst_ov", int'(out_valid), 0);
        chk("mid_rst_rdy", int'(in_ready), 0);
        check_pos("mid_rst_pos");
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rst_ov2", int'(out_valid), 0);

        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                for (int k = 0; k < 6; k++) f[k] = $urandom_range(0, 25);
                if ($urandom_range(0, 3) == 0)
                    f[$urandom_range(0, 5)] = $urandom_range(26, 31);
                cfg(f[0], f[1], f[2], f[3], f[4], f[5]);
            end else begin
                if ($urandom_range(0, 9) == 0)
                    cc = $urandom_range(26, 31);
                else
                    cc = $urandom_range(0, 25);
                send(cc, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
